uart_code_loader: RTL and testbench
===================================

UART_CODE_LOADER -- requirements
Module: uart_code_loader

Interface
REQ-001 SHALL have parameter CODE_BITWIDTH, default 16, meaning the code word width written to program memory.
REQ-002 SHALL have parameter ADDR_BITWIDTH, default 16, meaning the program memory address width.
REQ-003 SHALL have parameter DEPTH, default 256, meaning the maximum accepted word count.
REQ-004 SHALL have port clk, input, 1, the single clock for all logic.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port in_data, input, 8, the received byte from the uart receiver.
REQ-007 SHALL have port in_ready, input, 1, level-high while in_data is valid.
REQ-008 SHALL have port in_done, output, 1, a one-cycle pulse consuming the current byte.
REQ-009 SHALL have port mem_addr, output, ADDR_BITWIDTH, the program memory write address.
REQ-010 SHALL have port mem_data, output, CODE_BITWIDTH, the program memory write data.
REQ-011 SHALL have port mem_wr, output, 1, a one-cycle write strobe.
REQ-012 SHALL have port run, output, 1, high when a valid image is loaded; it drives the execution unit's active-low reset.
REQ-013 SHALL have port err, output, 1, sticky frame-error flag.

Function
REQ-014 SHALL accept frames of: 0xA5 sync, LEN_H, LEN_L (word count N), N words of 2 bytes each (low byte first), then a CSUM byte.
REQ-015 SHALL consume a byte only when in_ready=1 and no in_done was issued in the previous cycle, asserting in_done for exactly 1 cycle.
REQ-016 SHALL wait at least one cycle after in_done before sampling in_ready again, so one byte is never consumed twice.
REQ-017 SHALL implement states IDLE, LEN_H, LEN_L, DATA_L, DATA_H, CSUM, RUN, ERR, advancing one state per consumed byte.
REQ-018 SHALL, in IDLE, consume and discard any byte other than 0xA5; 0xA5 moves the FSM to LEN_H and clears err.
REQ-019 SHALL go from LEN_L to CSUM when N=0, to ERR when N>DEPTH, and to DATA_L otherwise.
REQ-020 SHALL, on consuming the high byte in DATA_H, pulse mem_wr in the following cycle with mem_addr = word index (from 0) and mem_data = {high, low}.
REQ-021 SHALL go to CSUM after word N-1; the word index SHALL NOT wrap.
REQ-022 SHALL keep the checksum as the 8-bit XOR of all payload bytes; LEN and sync bytes are excluded.
REQ-023 SHALL go to RUN when CSUM matches, and to ERR otherwise.
REQ-024 SHALL hold run=1 only in RUN; run SHALL drop in the cycle after a 0xA5 is consumed in RUN, which restarts a load at LEN_H.
REQ-025 SHALL, in RUN, consume and ignore any byte other than 0xA5.
REQ-026 SHALL, in ERR, set err=1 and return to IDLE in the next cycle.

Reset
REQ-027 SHALL, while rst=1, force state IDLE and in_done, mem_wr, run and err to 0, with mem_addr, mem_data and the checksum at 0.
REQ-028 SHALL, on rst asserted mid-frame, abandon the frame immediately with no further mem_wr; a partially written memory is not cleared.

Structure
REQ-029 SHALL place the state encoding, SYNC_BYTE = 8'hA5 and the frame field constants in a shared package bxu_pkg.
REQ-030 SHALL contain a single sub-module, byte_handshake, which generates in_done and the one-cycle byte-accept strobe.

Verification
REQ-031 SHALL cover: frame A5 00 02 34 12 78 56 CSUM=0x08 -> writes (0,0x1234) and (1,0x5678), then run=1.
REQ-032 SHALL cover: same frame with CSUM=0x09 -> both writes occur, run=0, err=1, FSM in IDLE.
REQ-033 SHALL cover: bytes 00 FF before A5 00 00 00 -> bytes discarded, no mem_wr, run=1.
REQ-034 SHALL cover: A5 01 01 with DEPTH=256 (N=257) -> err=1, no mem_wr.
REQ-035 SHALL cover: in RUN, 0x11 -> run stays 1; then 0xA5 -> run=0 next cycle.
REQ-036 SHALL cover: rst pulse after the first data byte -> all outputs 0, a subsequent valid frame loads correctly, and in_done pulses once per in_ready assertion throughout.

Source files
------------

// File: rtl/bxu_pkg.sv
// Shared definitions for the UART code loader: FSM encoding, sync byte
// and frame field widths.
package bxu_pkg;

  localparam logic [7:0] SYNC_BYTE     = 8'hA5;
  localparam int         BYTE_BITWIDTH = 8;
  localparam int         LEN_BITWIDTH  = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_H  = 3'd1,
    LEN_L  = 3'd2,
    DATA_L = 3'd3,
    DATA_H = 3'd4,
    CSUM   = 3'd5,
    RUN    = 3'd6,
    ERR    = 3'd7
  } loader_state_t;

  // Running frame checksum is a plain XOR over the payload bytes
  function automatic logic [BYTE_BITWIDTH-1:0] csum_next(
    input logic [BYTE_BITWIDTH-1:0] csum,
    input logic [BYTE_BITWIDTH-1:0] data
  );
    return csum ^ data;
  endfunction

endpackage

// File: rtl/byte_handshake.sv
// Byte handshake toward the UART receiver: accepts one byte per in_ready
// assertion, pulses in_done for one cycle and then holds off for one more
// cycle so a receiver that is slow to drop in_ready is not read twice.
module byte_handshake
  import bxu_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_ready,
  input  logic [BYTE_BITWIDTH-1:0] in_data,
  output logic                     in_done,
  output logic                     accept,
  output logic [BYTE_BITWIDTH-1:0] rx_byte
);

  logic done_q;
  logic holdoff_q;

  // Capture the byte and raise the done/accept pulse, skipping the cycle of
  // the pulse and the cycle right after it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q    <= 1'b0;
      holdoff_q <= 1'b0;
      rx_byte   <= '0;
    end else begin
      holdoff_q <= done_q;
      done_q    <= 1'b0;
      if (in_ready && !done_q && !holdoff_q) begin
        done_q  <= 1'b1;
        rx_byte <= in_data;
      end
    end
  end

  assign in_done = done_q;
  assign accept  = done_q;

endmodule

// File: rtl/uart_code_loader.sv
// UART code loader: parses A5 / LEN_H / LEN_L / N words (low byte first) /
// CSUM frames, writes each word into program memory and releases the
// execution unit (run=1) once the checksum matches.
module uart_code_loader
  import bxu_pkg::*;
#(
  parameter int CODE_BITWIDTH = 16,
  parameter int ADDR_BITWIDTH = 16,
  parameter int DEPTH         = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               in_data,
  input  logic                     in_ready,
  output logic                     in_done,
  output logic [ADDR_BITWIDTH-1:0] mem_addr,
  output logic [CODE_BITWIDTH-1:0] mem_data,
  output logic                     mem_wr,
  output logic                     run,
  output logic                     err
);

  localparam logic [LEN_BITWIDTH-1:0] DEPTH_LEN = LEN_BITWIDTH'(DEPTH);

  logic                     accept;
  logic [BYTE_BITWIDTH-1:0] rx_byte;
  loader_state_t            state;
  logic [BYTE_BITWIDTH-1:0] csum;
  logic [BYTE_BITWIDTH-1:0] low_byte;
  logic [BYTE_BITWIDTH-1:0] len_h;
  logic [LEN_BITWIDTH-1:0]  word_count;
  logic [LEN_BITWIDTH-1:0]  word_idx;
  logic [LEN_BITWIDTH-1:0]  len_full;

  byte_handshake u_handshake (
    .clk      (clk),
    .rst      (rst),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_done  (in_done),
    .accept   (accept),
    .rx_byte  (rx_byte)
  );

  assign len_full = {len_h, rx_byte};

  // Frame parser: one state step per accepted byte; ERR is left on its own
  // after a single cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      csum       <= '0;
      low_byte   <= '0;
      len_h      <= '0;
      word_count <= '0;
      word_idx   <= '0;
      mem_addr   <= '0;
      mem_data   <= '0;
      mem_wr     <= 1'b0;
      run        <= 1'b0;
      err        <= 1'b0;
    end else begin
      mem_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && rx_byte == SYNC_BYTE) begin
            state <= LEN_H;
            err   <= 1'b0;
            csum  <= '0;
          end
        end
        LEN_H: begin
          if (accept) begin
            len_h <= rx_byte;
            state <= LEN_L;
          end
        end
        LEN_L: begin
          if (accept) begin
            word_count <= len_full;
            word_idx   <= '0;
            if (len_full == '0)
              state <= CSUM;
            else if (len_full > DEPTH_LEN)
              state <= ERR;
            else
              state <= DATA_L;
          end
        end
        DATA_L: begin
          if (accept) begin
            low_byte <= rx_byte;
            csum     <= csum_next(csum, rx_byte);
            state    <= DATA_H;
          end
        end
        DATA_H: begin
          if (accept) begin
            mem_addr <= ADDR_BITWIDTH'(word_idx);
            mem_data <= CODE_BITWIDTH'({rx_byte, low_byte});
            mem_wr   <= 1'b1;
            csum     <= csum_next(csum, rx_byte);
            word_idx <= word_idx + 1'b1;
            if (word_idx == word_count - 1'b1)
              state <= CSUM;
            else
              state <= DATA_L;
          end
        end
        CSUM: begin
          if (accept) begin
            if (rx_byte == csum) begin
              state <= RUN;
              run   <= 1'b1;
            end else begin
              state <= ERR;
            end
          end
        end
        RUN: begin
          if (accept && rx_byte == SYNC_BYTE) begin
            state <= LEN_H;
            run   <= 1'b0;
            csum  <= '0;
          end
        end
        ERR: begin
          err   <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_code_loader.sv
// Directed bench for uart_code_loader: frames with hand-computed checksums,
// bad checksum, oversize length, RUN re-sync and mid-frame reset.
module tb_uart_code_loader;
  import bxu_pkg::*;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        in_done;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_wr;
  logic        run;
  logic        err;

  int checks;
  int errors;
  int sends;
  int done_count;
  int wr_count;
  logic [15:0] wr_addr [0:31];
  logic [15:0] wr_data [0:31];

  uart_code_loader #(
    .CODE_BITWIDTH (16),
    .ADDR_BITWIDTH (16),
    .DEPTH         (256)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_ready (in_ready),
    .in_done  (in_done),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_wr   (mem_wr),
    .run      (run),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count handshake pulses and record every memory write
  always @(negedge clk) begin
    if (in_done) done_count++;
    if (mem_wr && wr_count < 32) begin
      wr_addr[wr_count] = mem_addr;
      wr_data[wr_count] = mem_data;
      wr_count++;
    end else if (mem_wr) begin
      wr_count++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present one byte, wait (bounded) for in_done, then drop in_ready;
  // returns at the falling edge inside the in_done cycle
  task automatic applyStimulus(input logic [7:0] b);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    in_data  = b;
    in_ready = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (in_done) seen = 1'b1;
    end
    in_ready = 1'b0;
    if (seen) sends++;
    else checkOutput("in_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    checks = 0; errors = 0; sends = 0; done_count = 0; wr_count = 0;
    in_data = 8'h00; in_ready = 1'b0; rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_in_done", 32'(in_done), 32'd0);
    checkOutput("reset_mem_wr", 32'(mem_wr), 32'd0);
    checkOutput("reset_run", 32'(run), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    checkOutput("reset_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("reset_mem_data", 32'(mem_data), 32'd0);
    checkOutput("reset_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b0;
    settle();

    // Good two-word frame, checksum 34^12^78^56 = 08
    applyStimulus(8'hA5); applyStimulus(8'h00); applyStimulus(8'h02);
    applyStimulus(8'h34); applyStimulus(8'h12);
    applyStimulus(8'h78); applyStimulus(8'h56);
    applyStimulus(8'h08);
    settle();
    checkOutput("good_wr_count", 32'(wr_count), 32'd2);
    checkOutput("good_wr0_addr", 32'(wr_addr[0]), 32'h0000);
    checkOutput("good_wr0_data", 32'(wr_data[0]), 32'h1234);
    checkOutput("good_wr1_addr", 32'(wr_addr[1]), 32'h0001);
    checkOutput("good_wr1_data", 32'(wr_data[1]), 32'h5678);
    checkOutput("good_run", 32'(run), 32'd1);
    checkOutput("good_err", 32'(err), 32'd0);

    // In RUN: a non-sync byte is ignored, sync drops run one cycle later
    applyStimulus(8'h11);
    settle();
    checkOutput("run_ignore_11", 32'(run), 32'd1);
    applyStimulus(8'hA5);
    checkOutput("run_still_in_accept", 32'(run), 32'd1);
    @(negedge clk);
    checkOutput("run_drop_after_a5", 32'(run), 32'd0);
    checkOutput("resync_state", 32'(dut.state), 32'(LEN_H));

    // Same frame body with a wrong checksum
    wr_count = 0;
    applyStimulus(8'h00); applyStimulus(8'h02);
    applyStimulus(8'h34); applyStimulus(8'h12);
    applyStimulus(8'h78); applyStimulus(8'h56);
    applyStimulus(8'h09);
    settle();
    checkOutput("badcs_wr_count", 32'(wr_count), 32'd2);
    checkOutput("badcs_wr1_data", 32'(wr_data[1]), 32'h5678);
    checkOutput("badcs_run", 32'(run), 32'd0);
    checkOutput("badcs_err", 32'(err), 32'd1);
    checkOutput("badcs_state", 32'(dut.state), 32'(IDLE));

    // Junk bytes discarded, then an empty frame loads and clears err
    wr_count = 0;
    applyStimulus(8'h00); applyStimulus(8'hFF);
    applyStimulus(8'hA5); applyStimulus(8'h00);
    applyStimulus(8'h00); applyStimulus(8'h00);
    settle();
    checkOutput("empty_wr_count", 32'(wr_count), 32'd0);
    checkOutput("empty_run", 32'(run), 32'd1);
    checkOutput("empty_err", 32'(err), 32'd0);

    // Oversize length 0x0101 = 257 > 256
    applyStimulus(8'hA5); applyStimulus(8'h01); applyStimulus(8'h01);
    settle();
    checkOutput("oversize_err", 32'(err), 32'd1);
    checkOutput("oversize_run", 32'(run), 32'd0);
    checkOutput("oversize_wr_count", 32'(wr_count), 32'd0);
    checkOutput("oversize_state", 32'(dut.state), 32'(IDLE));

    // Reset after the first data byte abandons the frame
    applyStimulus(8'hA5); applyStimulus(8'h00); applyStimulus(8'h02);
    applyStimulus(8'h34);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_in_done", 32'(in_done), 32'd0);
    checkOutput("midrst_mem_wr", 32'(mem_wr), 32'd0);
    checkOutput("midrst_run", 32'(run), 32'd0);
    checkOutput("midrst_err", 32'(err), 32'd0);
    checkOutput("midrst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("midrst_mem_data", 32'(mem_data), 32'd0);
    checkOutput("midrst_state", 32'(dut.state), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    settle();
    checkOutput("midrst_no_wr", 32'(wr_count), 32'd0);

    // Full valid frame after the reset
    applyStimulus(8'hA5); applyStimulus(8'h00); applyStimulus(8'h02);
    applyStimulus(8'h34); applyStimulus(8'h12);
    applyStimulus(8'h78); applyStimulus(8'h56);
    applyStimulus(8'h08);
    settle();
    checkOutput("reload_wr_count", 32'(wr_count), 32'd2);
    checkOutput("reload_wr0_addr", 32'(wr_addr[0]), 32'h0000);
    checkOutput("reload_wr0_data", 32'(wr_data[0]), 32'h1234);
    checkOutput("reload_wr1_addr", 32'(wr_addr[1]), 32'h0001);
    checkOutput("reload_wr1_data", 32'(wr_data[1]), 32'h5678);
    checkOutput("reload_run", 32'(run), 32'd1);

    // One in_done per byte presented across the whole run
    checkOutput("done_per_byte", 32'(done_count), 32'(sends));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
